// File: rtl/digit_counter_chain.sv
// digit_counter_chain
//   Multi-digit up/down counter for the stopwatch datapath. NUM_DIGITS 4-bit
//   digits live in one register; carry (up) / borrow (down) ripples through
//   all digits combinationally, so a whole-chain step takes one cycle.
//   Even-indexed digits count modulo BASE_EVEN, odd-indexed modulo BASE_ODD
//   (defaults 10/6 give mm:ss).
//
//   Optional build macro: SATURATE_EN -- when defined, a step taken at the
//   terminal value is suppressed (count holds) and rollover is tied low.
//   Undefined (default): full wrap-around with a registered rollover pulse.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   enable      advance one step this cycle
//   up_down     1 = count up, 0 = count down (sampled with enable)
//   load        synchronous parallel load, wins over enable
//   load_value  digit i on bits [4i+3:4i]; out-of-range digits load as 0
//   count       registered counter value
//   at_limit    combinational: count is at the terminal value for up_down
//   rollover    one-cycle pulse after a wrap step
module digit_counter_chain #(
    parameter int NUM_DIGITS = 4,
    parameter int BASE_EVEN  = 10,
    parameter int BASE_ODD   = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    up_down,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    output logic [4*NUM_DIGITS-1:0] count,
    output logic                    at_limit,
    output logic                    rollover
);

    function automatic int base_of(input int idx);
        return (idx % 2 == 0) ? BASE_EVEN : BASE_ODD;
    endfunction

    logic [NUM_DIGITS-1:0][3:0] digits;
    logic [NUM_DIGITS-1:0][3:0] digits_next;
    logic [NUM_DIGITS-1:0][3:0] load_digits;
    logic [NUM_DIGITS-1:0]      term;
    logic [NUM_DIGITS:0]        chain;
    logic                       advance;

    assign load_digits = load_value;
    assign count       = digits;

    // Per-digit terminal detect for the current direction.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_term
            localparam logic [3:0] MAX = 4'(base_of(gi) - 1);
            assign term[gi] = up_down ? (digits[gi] == MAX) : (digits[gi] == 4'd0);
        end
    endgenerate

    // The whole chain sitting at its terminal value is exactly at_limit.
    assign at_limit = chain[NUM_DIGITS];

`ifdef SATURATE_EN
    assign advance = enable & ~at_limit;
`else
    assign advance = enable;
`endif

    // chain[k] = every digit below k is terminal, i.e. digit k receives the
    // carry/borrow. Built in one process so the ripple is a single comb path.
    always_comb begin
        chain       = '0;
        digits_next = digits;
        chain[0]    = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            chain[k+1] = chain[k] & term[k];
            if (load) begin
                digits_next[k] = ({1'b0, load_digits[k]} < 5'(base_of(k))) ? load_digits[k] : 4'd0;
            end else if (advance && chain[k]) begin
                if (up_down)
                    digits_next[k] = term[k] ? 4'd0 : digits[k] + 4'd1;
                else
                    digits_next[k] = term[k] ? 4'(base_of(k) - 1) : digits[k] - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) digits <= '0;
        else      digits <= digits_next;
    end

`ifdef SATURATE_EN
    assign rollover = 1'b0;
`else
    logic roll_q;
    // A wrap step is any non-load step taken while the chain is at its limit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) roll_q <= 1'b0;
        else      roll_q <= ~load & enable & at_limit;
    end
    assign rollover = roll_q;
`endif

endmodule

// File: tb/tb_digit_counter_chain.sv
// Bench for digit_counter_chain (default parameters, mm:ss).
// Table of load/step vectors plus hand-written reset and count sequences;
// every expected result is queued when driven and popped after the edge.
module tb_digit_counter_chain;

`ifdef SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        up_down = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_value = '0;
    logic [15:0] count;
    logic        at_limit;
    logic        rollover;

    always #5 clk = ~clk;

    digit_counter_chain #(.NUM_DIGITS(4), .BASE_EVEN(10), .BASE_ODD(6)) dut (
        .clk(clk), .rst(rst), .enable(enable), .up_down(up_down), .load(load),
        .load_value(load_value), .count(count), .at_limit(at_limit), .rollover(rollover)
    );

    typedef struct {
        logic [15:0] cnt;
        logic        roll;
        logic        lim;
        string       name;
    } exp_t;

    typedef struct {
        logic        ld, en, ud;
        logic [15:0] lv;
        logic [15:0] ec;
        logic        er, el;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[14];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic ld, en, ud, input logic [15:0] lv,
                                input logic [15:0] ec, input logic er, el);
        vec_t v;
        v.ld = ld; v.en = en; v.ud = ud; v.lv = lv; v.ec = ec; v.er = er; v.el = el;
        return v;
    endfunction

    function automatic exp_t ex(input logic [15:0] c, input logic r, l, input string n);
        exp_t e;
        e.cnt = c; e.roll = r; e.lim = l; e.name = n;
        return e;
    endfunction

    // Drive one cycle at the falling edge, queue the expectation, compare after the edge.
    task automatic cyc(input logic ld, en, ud, input logic [15:0] lv, input exp_t e);
        exp_t x;
        @(negedge clk);
        load = ld; enable = en; up_down = ud; load_value = lv;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_empty actual=0 required=1");
        end else begin
            x = sb.pop_front();
            chk({x.name, "_count"}, count, x.cnt);
            chk({x.name, "_rollover"}, {15'd0, rollover}, {15'd0, x.roll});
            chk({x.name, "_at_limit"}, {15'd0, at_limit}, {15'd0, x.lim});
        end
    endtask

    // Stopwatch reference: seconds -> mm:ss BCD digits.
    function automatic logic [15:0] mmss(input int n);
        int m, s;
        m = n / 60;
        s = n % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    initial begin
        //                 ld    en    ud    load_value  count                 roll      at_limit
        vecs[0]  = mk(1'b1, 1'b0, 1'b1, 16'h5959, 16'h5959,                1'b0,     1'b1);
        vecs[1]  = mk(1'b0, 1'b1, 1'b1, 16'h0000, SAT ? 16'h5959 : 16'h0000, ~SAT,   SAT);
        vecs[2]  = mk(1'b0, 1'b0, 1'b1, 16'h0000, SAT ? 16'h5959 : 16'h0000, 1'b0,   SAT);
        vecs[3]  = mk(1'b1, 1'b0, 1'b0, 16'h0100, 16'h0100,                1'b0,     1'b0);
        vecs[4]  = mk(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0059,                1'b0,     1'b0);
        vecs[5]  = mk(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000,                1'b0,     1'b1);
        vecs[6]  = mk(1'b0, 1'b1, 1'b0, 16'h0000, SAT ? 16'h0000 : 16'h5959, ~SAT,   SAT);
        vecs[7]  = mk(1'b1, 1'b1, 1'b1, 16'h7A3C, 16'h0030,                1'b0,     1'b0);
        vecs[8]  = mk(1'b1, 1'b0, 1'b1, 16'h0009, 16'h0009,                1'b0,     1'b0);
        vecs[9]  = mk(1'b0, 1'b1, 1'b1, 16'h0000, 16'h0010,                1'b0,     1'b0);
        vecs[10] = mk(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0009,                1'b0,     1'b0);
        vecs[11] = mk(1'b1, 1'b0, 1'b1, 16'h5959, 16'h5959,                1'b0,     1'b1);
        vecs[12] = mk(1'b0, 1'b1, 1'b1, 16'h0000, SAT ? 16'h5959 : 16'h0000, ~SAT,   SAT);
        vecs[13] = mk(1'b1, 1'b1, 1'b1, 16'h1234, 16'h1234,                1'b0,     1'b0);

        // Reset state, at_limit tracks direction while held in reset.
        #2;
        chk("reset_count", count, 16'h0000);
        chk("reset_rollover", {15'd0, rollover}, 16'h0000);
        chk("reset_limit_down", {15'd0, at_limit}, 16'h0001);
        up_down = 1'b1;
        #1;
        chk("reset_limit_up", {15'd0, at_limit}, 16'h0000);
        @(negedge clk);
        rst = 1'b1;

        // 60 one-second steps: 00:00 -> 01:00.
        for (int n = 1; n <= 60; n++)
            cyc(1'b0, 1'b1, 1'b1, 16'h0000, ex(mmss(n), 1'b0, 1'b0, $sformatf("step%0d", n)));
        chk("sixty_steps", count, 16'h0100);

        // Table of loads, wraps, borrows, clamp/priority and direction change.
        foreach (vecs[i])
            cyc(vecs[i].ld, vecs[i].en, vecs[i].ud, vecs[i].lv,
                ex(vecs[i].ec, vecs[i].er, vecs[i].el, $sformatf("vec%0d", i)));
        cyc(1'b0, 1'b0, 1'b1, 16'h0000, ex(16'h1234, 1'b0, 1'b0, "hold"));

        // Async reset between edges while count = 03:12.
        cyc(1'b1, 1'b0, 1'b1, 16'h0312, ex(16'h0312, 1'b0, 1'b0, "load0312"));
        load = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("async_rst_count", count, 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        cyc(1'b0, 1'b1, 1'b1, 16'h0000, ex(16'h0001, 1'b0, 1'b0, "first_after_rst"));

        // Async reset right after a wrap clears the rollover pulse immediately.
        cyc(1'b1, 1'b0, 1'b1, 16'h5959, ex(16'h5959, 1'b0, 1'b1, "reload5959"));
        cyc(1'b0, 1'b1, 1'b1, 16'h0000,
            ex(SAT ? 16'h5959 : 16'h0000, ~SAT, SAT, "wrap_before_rst"));
        enable = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("async_rst_rollover", {15'd0, rollover}, 16'h0000);
        chk("async_rst_count2", count, 16'h0000);
        @(negedge clk);
        rst = 1'b1;

        // Saturation (or wrap) at 59:59 is left by reversing direction.
        cyc(1'b1, 1'b0, 1'b1, 16'h5959, ex(16'h5959, 1'b0, 1'b1, "sat_load"));
        cyc(1'b0, 1'b1, 1'b0, 16'h0000, ex(16'h5958, 1'b0, 1'b0, "reverse_down"));

        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_leftover actual=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
